// File: rtl/universal_shift_rotate_pkg.sv
// Shared op-codes and FSM state encodings for the universal shift/rotate register.
// Imported by the top level, the single-step shifter and the testbench.
package universal_shift_rotate_pkg;

   localparam logic [2:0] OP_HOLD = 3'd0;
   localparam logic [2:0] OP_SHL  = 3'd1;
   localparam logic [2:0] OP_SHR  = 3'd2;
   localparam logic [2:0] OP_ROL  = 3'd3;
   localparam logic [2:0] OP_ROR  = 3'd4;
   localparam logic [2:0] OP_ASR  = 3'd5;
   localparam logic [2:0] OP_LOAD = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // True for the five ops that take Amt steps through RUN.
   function automatic logic is_step_op(input logic [2:0] op);
      return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
             (op == OP_ROR) || (op == OP_ASR);
   endfunction

endpackage

// File: rtl/universal_shift_rotate_shift_step.sv
// Combinational single-position shift/rotate of a WIDTH-bit word.
// out_bit is the bit that leaves the word on this step.
module universal_shift_rotate_shift_step
   import universal_shift_rotate_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_q,
   input  logic [2:0]       i_op,
   input  logic             i_ser_in_l,
   input  logic             i_ser_in_r,
   output logic [WIDTH-1:0] o_next_q,
   output logic             o_out_bit
);

   always_comb begin
      o_next_q  = i_q;
      o_out_bit = 1'b0;
      case (i_op)
         OP_SHL: begin
            o_next_q  = {i_q[WIDTH-2:0], i_ser_in_r};
            o_out_bit = i_q[WIDTH-1];
         end
         OP_SHR: begin
            o_next_q  = {i_ser_in_l, i_q[WIDTH-1:1]};
            o_out_bit = i_q[0];
         end
         OP_ROL: begin
            o_next_q  = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
            o_out_bit = i_q[WIDTH-1];
         end
         OP_ROR: begin
            o_next_q  = {i_q[0], i_q[WIDTH-1:1]};
            o_out_bit = i_q[0];
         end
         OP_ASR: begin
            o_next_q  = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
            o_out_bit = i_q[0];
         end
         default: begin
            o_next_q  = i_q;
            o_out_bit = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/universal_shift_rotate.sv
// Sequential shifter: parallel load plus multi-position shift/rotate, one step per clock,
// sequenced by a start/busy/done FSM.
//
// state  | meaning
// S_IDLE | waiting for Start; q held
// S_RUN  | one shift/rotate step per edge until counter reaches zero
// S_DONE | done pulse for one cycle, then back to S_IDLE
module universal_shift_rotate
   import universal_shift_rotate_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH) + 1
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             SET,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [AMT_W-1:0] Amt,
   input  logic [WIDTH-1:0] D,
   input  logic             Ser_In_L,
   input  logic             Ser_In_R,
   output logic [WIDTH-1:0] q,
   output logic             Ser_Out,
   output logic             busy,
   output logic             done
);

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_q, w_q_nxt;
   logic [AMT_W-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]       r_op, w_op_nxt;
   logic             r_ser_out, w_ser_out_nxt;
   logic [WIDTH-1:0] w_step_q;
   logic             w_step_bit;

   universal_shift_rotate_shift_step #(.WIDTH(WIDTH)) u_step (
      .i_q        (r_q),
      .i_op       (r_op),
      .i_ser_in_l (Ser_In_L),
      .i_ser_in_r (Ser_In_R),
      .o_next_q   (w_step_q),
      .o_out_bit  (w_step_bit)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_q_nxt       = r_q;
      w_cnt_nxt     = r_cnt;
      w_op_nxt      = r_op;
      w_ser_out_nxt = r_ser_out;
      case (r_state)
         S_IDLE: begin
            if (Start) begin
               if (Op == OP_LOAD) begin
                  w_q_nxt     = D;
                  w_state_nxt = S_DONE;
               end else if (is_step_op(Op) && (Amt != '0)) begin
                  w_op_nxt    = Op;
                  w_cnt_nxt   = Amt;
                  w_state_nxt = S_RUN;
               end else begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_RUN: begin
            w_q_nxt       = w_step_q;
            w_ser_out_nxt = w_step_bit;
            w_cnt_nxt     = r_cnt - AMT_W'(1);
            if (r_cnt == AMT_W'(1)) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // SET only presets q and aborts the FSM; the serial output keeps its last value.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_state   <= S_IDLE;
         r_q       <= '0;
         r_cnt     <= '0;
         r_op      <= OP_HOLD;
         r_ser_out <= 1'b0;
      end else if (SET) begin
         r_state   <= S_IDLE;
         r_q       <= '1;
         r_cnt     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_q       <= w_q_nxt;
         r_cnt     <= w_cnt_nxt;
         r_op      <= w_op_nxt;
         r_ser_out <= w_ser_out_nxt;
      end
   end

   assign q       = r_q;
   assign Ser_Out = r_ser_out;
   assign busy    = (r_state != S_IDLE);
   assign done    = (r_state == S_DONE);

endmodule
